// File: rtl/ext_mem_port_ctrl.sv
// External memory port controller: HEIGHT x WIDTH storage behind valid/ready
// read and write request ports, a single-entry backpressured read-response
// register, an optional one-access-per-cycle arbiter and saturating word
// counters for boundary bandwidth accounting.
module ext_mem_port_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned HEIGHT      = 256,
  parameter bit          SINGLE_PORT = 1'b0,
  parameter int unsigned CNT_WIDTH   = 32,
  localparam int unsigned AW         = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [AW-1:0]        rd_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] rd_word_cnt,
  output logic [CNT_WIDTH-1:0] wr_word_cnt
);

  typedef enum logic {GrantRead, GrantWrite} grant_e;

  grant_e               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]     mem [HEIGHT];
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_data_q;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                 rsp_free;
  logic                 rd_fire;
  logic                 wr_fire;

  // Response register can take a new word if empty or being popped now
  assign rsp_free = !rsp_valid_q || rsp_ready;
  assign rd_fire  = rd_valid && rd_ready;
  assign wr_fire  = wr_valid && wr_ready;

  // Arbiter state register
  always_ff @(posedge clk) begin
    if (rst_in) begin
      last_grant_q <= GrantWrite;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // Arbiter next state: remember the last winner so contention alternates
  always_comb begin
    last_grant_d = last_grant_q;
    if (rd_fire) begin
      last_grant_d = GrantRead;
    end else if (wr_fire) begin
      last_grant_d = GrantWrite;
    end
  end

  // Grant outputs; each ready looks only at the other side's valid
  always_comb begin
    if (SINGLE_PORT) begin
      rd_ready = rsp_free && (!wr_valid || (last_grant_q == GrantWrite));
      wr_ready = !(rd_valid && rsp_free) || (last_grant_q == GrantRead);
    end else begin
      rd_ready = rsp_free;
      wr_ready = 1'b1;
    end
    // Nothing is accepted while reset is held
    if (rst_in) begin
      rd_ready = 1'b0;
      wr_ready = 1'b0;
    end
  end

  // Storage array write; deliberately unreset so contents survive rst_in
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Response valid next state: load on read, drop on pop without reload
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (rd_fire) begin
      rsp_valid_d = 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response register; reads sample the pre-write word (read-before-write)
  always_ff @(posedge clk) begin
    if (rst_in) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (rd_fire) begin
        rsp_data_q <= mem[rd_addr];
      end
    end
  end

  // Counter next state: clear wins, otherwise saturating increment
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (cnt_clear) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if (rd_fire && (rd_cnt_q != '1)) begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
      if (wr_fire && (wr_cnt_q != '1)) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst_in) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rd_word_cnt = rd_cnt_q;
  assign wr_word_cnt = wr_cnt_q;

endmodule

// File: tb/tb_ext_mem_port_ctrl.sv
// Bench for ext_mem_port_ctrl: a dual-port and a single-port instance share
// one stimulus stream; a transaction-level model checks both every cycle and
// directed literal checks pin the model to hand-computed values.
module tb_ext_mem_port_ctrl;
  localparam int unsigned W  = 32;
  localparam int unsigned H  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;
  localparam int          SAT = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_in, wr_valid, rd_valid, rsp_ready, cnt_clear;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data;
  logic          wr_ready  [2];
  logic          rd_ready  [2];
  logic          rsp_valid [2];
  logic [W-1:0]  rsp_data  [2];
  logic [CW-1:0] rd_cnt    [2];
  logic [CW-1:0] wr_cnt    [2];

  ext_mem_port_ctrl #(
    .WIDTH(W), .HEIGHT(H), .SINGLE_PORT(1'b0), .CNT_WIDTH(CW)
  ) u_dual (
    .clk(clk), .rst_in(rst_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready[0]), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready[0]), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]),
    .cnt_clear(cnt_clear), .rd_word_cnt(rd_cnt[0]), .wr_word_cnt(wr_cnt[0])
  );

  ext_mem_port_ctrl #(
    .WIDTH(W), .HEIGHT(H), .SINGLE_PORT(1'b1), .CNT_WIDTH(CW)
  ) u_single (
    .clk(clk), .rst_in(rst_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready[1]), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready[1]), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]),
    .cnt_clear(cnt_clear), .rd_word_cnt(rd_cnt[1]), .wr_word_cnt(wr_cnt[1])
  );

  int errors = 0;
  int checks = 0;

  // Model state, index 0 = dual-port, 1 = single-port
  logic [W-1:0] m_mem    [2][H];
  bit           m_known  [2][H];
  bit           m_rsp_v  [2];
  logic [W-1:0] m_rsp_d  [2];
  bit           m_rsp_k  [2];
  int           m_rd     [2];
  int           m_wr     [2];
  bit           m_last_rd[2];
  bit           armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Who wins: dual grants both; single alternates under contention
  function automatic void arb(input int m, input bit rd_req, input bit wr_req,
                              input bit last_rd, output bit g_rd, output bit g_wr);
    if (m == 1 && rd_req && wr_req) begin
      g_rd = !last_rd;
      g_wr = last_rd;
    end else begin
      g_rd = rd_req;
      g_wr = wr_req;
    end
  endfunction

  // Model: advance by one transaction step at each rising edge
  initial begin
    bit free, gr, gw;
    forever begin
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
        if (rst_in) begin
          m_rsp_v[m] = 1'b0; m_rsp_d[m] = '0; m_rsp_k[m] = 1'b1;
          m_rd[m] = 0; m_wr[m] = 0; m_last_rd[m] = 1'b0;
        end else begin
          free = !m_rsp_v[m] || rsp_ready;
          arb(m, rd_valid && free, wr_valid, m_last_rd[m], gr, gw);
          if (gr) begin
            m_rsp_d[m] = m_mem[m][rd_addr];
            m_rsp_k[m] = m_known[m][rd_addr];
            m_rsp_v[m] = 1'b1;
            m_last_rd[m] = 1'b1;
          end else if (m_rsp_v[m] && rsp_ready) begin
            m_rsp_v[m] = 1'b0;
          end
          if (gw) begin
            m_mem[m][wr_addr] = wr_data;
            m_known[m][wr_addr] = 1'b1;
            if (!gr) m_last_rd[m] = 1'b0;
          end
          if (cnt_clear) begin
            m_rd[m] = 0; m_wr[m] = 0;
          end else begin
            if (gr && m_rd[m] < SAT) m_rd[m]++;
            if (gw && m_wr[m] < SAT) m_wr[m]++;
          end
        end
      end
      if (rst_in) armed = 1'b1;
    end
  end

  // Compare: every falling edge once the model has seen a reset
  initial begin
    bit er, ew, dummy;
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int m = 0; m < 2; m++) begin
          chk($sformatf("m%0d rsp_valid", m), 32'(rsp_valid[m]), 32'(m_rsp_v[m]));
          if (m_rsp_v[m] && m_rsp_k[m])
            chk($sformatf("m%0d rsp_data", m), rsp_data[m], m_rsp_d[m]);
          chk($sformatf("m%0d rd_cnt", m), 32'(rd_cnt[m]), 32'(m_rd[m]));
          chk($sformatf("m%0d wr_cnt", m), 32'(wr_cnt[m]), 32'(m_wr[m]));
          if (!rst_in) begin
            // A ready means "would be granted if this side asked"
            arb(m, !m_rsp_v[m] || rsp_ready, wr_valid, m_last_rd[m], er, dummy);
            arb(m, rd_valid && (!m_rsp_v[m] || rsp_ready), 1'b1, m_last_rd[m], dummy, ew);
            chk($sformatf("m%0d rd_ready", m), 32'(rd_ready[m]), 32'(er));
            chk($sformatf("m%0d wr_ready", m), 32'(wr_ready[m]), 32'(ew));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int m, input logic [31:0] got,
                     input logic [31:0] exp);
    chk($sformatf("lit m%0d %s", m, name), got, exp);
  endtask

  initial begin
    rst_in = 1'b1; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0; cnt_clear = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    step(); step();
    rst_in = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      lit("reset rsp_valid", m, 32'(rsp_valid[m]), 0);
      lit("reset rsp_data", m, rsp_data[m], 0);
      lit("reset rd_cnt", m, 32'(rd_cnt[m]), 0);
      lit("reset wr_cnt", m, 32'(wr_cnt[m]), 0);
      lit("reset rd_ready", m, 32'(rd_ready[m]), 1);
    end

    // Write then read back next cycle
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF; rsp_ready = 1'b1;
    step();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5;
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      lit("wr-rd rsp_valid", m, 32'(rsp_valid[m]), 1);
      lit("wr-rd rsp_data", m, rsp_data[m], 32'hDEADBEEF);
      lit("wr-rd wr_cnt", m, 32'(wr_cnt[m]), 1);
      lit("wr-rd rd_cnt", m, 32'(rd_cnt[m]), 1);
    end

    // Same-cycle collision returns the old word
    wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h11;
    step();
    wr_data = 32'h22; rd_valid = 1'b1; rd_addr = 4'd7;
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    lit("collision old", 0, rsp_data[0], 32'h11);
    lit("collision old", 1, rsp_data[1], 32'h11);
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    lit("collision new", 0, rsp_data[0], 32'h22);

    // Backpressure: drain, then one read held against rsp_ready=0
    step();
    rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5;
    step();
    rd_addr = 4'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lit("bp rd_ready", 0, 32'(rd_ready[0]), 0);
      lit("bp rsp_valid", 0, 32'(rsp_valid[0]), 1);
      lit("bp rsp_data", 0, rsp_data[0], 32'hDEADBEEF);
      step();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = (i % 2 == 0) ? 4'd7 : 4'd5;
      step();
      @(negedge clk);
      lit("b2b rsp_valid", 0, 32'(rsp_valid[0]), 1);
      lit("b2b rsp_data", 0, rsp_data[0], (i % 2 == 0) ? 32'h22 : 32'hDEADBEEF);
      lit("b2b rd_ready", 0, 32'(rd_ready[0]), 1);
    end
    rd_valid = 1'b0;

    // Continuous contention from reset: read first, then strict alternation
    rst_in = 1'b1;
    step();
    rst_in = 1'b0; rd_valid = 1'b1; wr_valid = 1'b1; rd_addr = 4'd5; wr_addr = 4'd9;
    for (int i = 0; i < 8; i++) begin
      wr_data = 32'(i);
      @(negedge clk);
      lit("alt rd_ready", 1, 32'(rd_ready[1]), (i % 2 == 0) ? 1 : 0);
      lit("alt wr_ready", 1, 32'(wr_ready[1]), (i % 2 == 0) ? 0 : 1);
      step();
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    lit("alt rd_cnt", 1, 32'(rd_cnt[1]), 4);
    lit("alt wr_cnt", 1, 32'(wr_cnt[1]), 4);
    lit("alt rd_cnt", 0, 32'(rd_cnt[0]), 8);
    lit("alt wr_cnt", 0, 32'(wr_cnt[0]), 8);

    // Saturation and clear priority
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0; wr_valid = 1'b1; wr_addr = 4'd10;
    for (int i = 0; i < 17; i++) begin
      wr_data = 32'(100 + i);
      step();
    end
    wr_valid = 1'b0;
    @(negedge clk);
    lit("sat wr_cnt", 0, 32'(wr_cnt[0]), 15);
    lit("sat wr_cnt", 1, 32'(wr_cnt[1]), 15);
    cnt_clear = 1'b1; wr_valid = 1'b1;
    step();
    cnt_clear = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    lit("clear wr_cnt", 0, 32'(wr_cnt[0]), 0);
    lit("clear wr_cnt", 1, 32'(wr_cnt[1]), 0);

    // Reset drops a stalled response; memory survives
    rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5;
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    lit("pre-rst rsp_valid", 0, 32'(rsp_valid[0]), 1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      lit("rst rsp_valid", m, 32'(rsp_valid[m]), 0);
      lit("rst rd_cnt", m, 32'(rd_cnt[m]), 0);
    end
    rd_valid = 1'b1;
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    lit("persist", 0, rsp_data[0], 32'hDEADBEEF);
    lit("persist", 1, rsp_data[1], 32'hDEADBEEF);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_in    = ($urandom_range(0, 199) == 0);
      cnt_clear = ($urandom_range(0, 49) == 0);
      wr_valid  = $urandom_range(0, 1) == 1;
      rd_valid  = $urandom_range(0, 1) == 1;
      rsp_ready = $urandom_range(0, 9) < 7;
      wr_addr   = 4'($urandom_range(0, H - 1));
      rd_addr   = 4'($urandom_range(0, H - 1));
      wr_data   = $urandom;
      step();
    end
    rst_in = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_mem_port_ctrl.md
# ext_mem_port_ctrl

Parametrised successor to the plain pseudo-2-port partial-sum memory used by the system wrapper. It wraps a HEIGHT×WIDTH storage array behind valid/ready read and write request ports and a backpressured read-response port. A SINGLE_PORT mode arbitrates one access per cycle to cut bandwidth. Saturating bandwidth counters record every word moved across the chip boundary.

## Interface
- WIDTH, 32, data word width in bits
- HEIGHT, 256, number of words; address width AW = $clog2(HEIGHT)
- SINGLE_PORT, 0, 0 = one read and one write per cycle; 1 = at most one access per cycle
- CNT_WIDTH, 32, width of each bandwidth counter
- clk  in  1  single clock, all state on rising edge
- rst_in  in  1  synchronous, active-high reset
- wr_valid  in  1  write request present
- wr_ready  out  1  write request accepted when wr_valid & wr_ready
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- rd_valid  in  1  read request present
- rd_ready  out  1  read request accepted when rd_valid & rd_ready
- rd_addr  in  AW  read address
- rsp_valid  out  1  read response held in output register
- rsp_ready  in  1  consumer takes response when rsp_valid & rsp_ready
- rsp_data  out  WIDTH  read response data
- cnt_clear  in  1  synchronous clear of both counters
- rd_word_cnt  out  CNT_WIDTH  accepted reads since reset/clear
- wr_word_cnt  out  CNT_WIDTH  accepted writes since reset/clear

## Operation
- Storage array is not reset; contents survive rst_in.
- Response register: single entry. It is "free" when rsp_valid=0 or (rsp_valid & rsp_ready) this cycle.
- Dual-port mode (SINGLE_PORT=0): wr_ready=1 always; rd_ready = response register free.
- Single-port mode: arbiter over the two requests, state `last_grant` ∈ {READ, WRITE}, reset to WRITE.
  - Only one requester valid (read also needing free response register): grant it.
  - Both eligible: grant the one not equal to last_grant (alternation); update last_grant on every grant.
  - Read not eligible (register full, no pop): write granted if valid.
  - wr_ready/rd_ready are combinational grant outputs; each may depend on the other's valid, never on its own.
- Same address read and write accepted in the same cycle (dual mode): the read returns the OLD word (read-before-write).
- Accepted read: rsp_data loads mem[rd_addr] at that edge, rsp_valid=1 next cycle. The register holds stable while rsp_valid & !rsp_ready.
- Pop with no new read: rsp_valid→0. Pop and new read in the same cycle: register reloads; rsp_valid stays 1.
- Counters: +1 per accepted read/write, saturate at all-ones (no wrap). cnt_clear takes priority over increment in the same cycle.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rd_word_cnt=0, wr_word_cnt=0, last_grant=WRITE. With rsp register empty after reset, rd_ready=1 (dual) or per arbiter (single).
- Read latency: request accepted in cycle N → rsp_valid=1 with data in cycle N+1.
- Write visibility: write accepted in cycle N is readable by a read accepted in cycle N+1.
- Throughput: dual mode 1 read + 1 write per cycle at rsp_ready=1. Single mode 1 access per cycle total; under continuous contention reads and writes alternate exactly.
- rst_in asserted mid-operation: the in-flight response is dropped (rsp_valid=0 next cycle). The counters clear. No write is performed in a cycle where rst_in=1.
- Counter updates appear the cycle after acceptance.

## Test plan
- Reset then dual mode: write 0xDEADBEEF to addr 5 in cycle 0, read addr 5 in cycle 1 -> rsp_valid=1, rsp_data=0xDEADBEEF in cycle 2; wr_word_cnt=1, rd_word_cnt=1.
- Same-cycle collision, dual mode: mem[7]=0x11, then write 0x22 and read addr 7 together -> rsp_data=0x11; next read of 7 -> 0x22.
- Backpressure: rsp_ready=0 after one read -> rd_ready=0, rsp_data stable for 5 cycles. Raise rsp_ready with rd_valid held -> back-to-back responses, no bubble.
- SINGLE_PORT=1, rd_valid=wr_valid=1 for 8 cycles, rsp_ready=1 -> grants W? no: first grant READ (last_grant=WRITE), then alternating R,W,R,W…; final counts 4 reads, 4 writes.
- Counter saturation with CNT_WIDTH=4: 17 accepted writes -> wr_word_cnt=15. cnt_clear together with a write -> count 0.
- rst_in pulse while rsp_valid=1 with rsp_ready=0 -> next cycle rsp_valid=0 and counters 0. Memory word written before the reset still reads back its value.
